// File: rtl/framebuffer_fill_engine.sv
// Framebuffer fill engine: streams one pixel write per clock into the frame memory
// write port. It supports solid fill, checkerboard, rectangle fill and clear.
// Every output is registered and is changed only by the FSM.
module framebuffer_fill_engine #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 1,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned HEIGHT     = 64,
    parameter int unsigned CHECK_LOG2 = 0,
    localparam int unsigned X_W       = $clog2(WIDTH),
    localparam int unsigned Y_W       = $clog2(HEIGHT)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ModeSolid   = 2'd0,
        ModeChecker = 2'd1,
        ModeRect    = 2'd2,
        ModeClear   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Last column/line of the frame. The one-bit-wider copies are used for the
    // range check, so that it stays meaningful when HEIGHT is not a power of two.
    localparam logic [X_W-1:0] XLast  = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] YLast  = Y_W'(HEIGHT - 1);
    localparam logic [X_W:0]   XLimit = (X_W + 1)'(WIDTH - 1);
    localparam logic [Y_W:0]   YLimit = (Y_W + 1)'(HEIGHT - 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [X_W-1:0]      x_lo_q, x_lo_d;
    logic [X_W-1:0]      x_hi_q, x_hi_d;
    logic [Y_W-1:0]      y_hi_q, y_hi_d;

    logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wren_q, wren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [X_W-1:0]      x_step;
    logic [Y_W-1:0]      y_step;
    logic                last_pixel;
    logic                rect_bad;
    mode_e               mode_in;
    logic [X_W-1:0]      start_x_lo;
    logic [X_W-1:0]      start_x_hi;
    logic [Y_W-1:0]      start_y_lo;
    logic [Y_W-1:0]      start_y_hi;

    // Pixel value for a coordinate under the given mode
    function automatic logic [DATA_W-1:0] pixel_data(input mode_e             m,
                                                     input logic [DATA_W-1:0] f,
                                                     input logic [X_W-1:0]    x,
                                                     input logic [Y_W-1:0]    y);
        logic [DATA_W-1:0] v;
        unique case (m)
            ModeClear:   v = '0;
            ModeChecker: v = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? ~f : f;
            ModeSolid:   v = f;
            ModeRect:    v = f;
            default:     v = f;
        endcase
        return v;
    endfunction

    // Linear address: WIDTH is a power of two, so y*WIDTH + x is just {y, x}
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        return ADDR_W'({y, x});
    endfunction

    assign mode_in = mode_e'(mode);

    // Decode the scan window and validate rectangle coordinates at start time
    always_comb begin
        rect_bad   = ((x0 > x1) || (y0 > y1) ||
                      ({1'b0, x1} > XLimit) || ({1'b0, y1} > YLimit));
        start_x_lo = '0;
        start_x_hi = XLast;
        start_y_lo = '0;
        start_y_hi = YLast;
        if (mode_in == ModeRect) begin
            start_x_lo = x0;
            start_x_hi = x1;
            start_y_lo = y0;
            start_y_hi = y1;
        end
    end

    // Raster step: x is the fast axis and wraps to the window's left edge
    always_comb begin
        x_step     = x_q + 1'b1;
        y_step     = y_q;
        last_pixel = (x_q == x_hi_q) && (y_q == y_hi_q);
        if (x_q == x_hi_q) begin
            x_step = x_lo_q;
            y_step = y_q + 1'b1;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fill_d      = fill_q;
        x_d         = x_q;
        y_d         = y_q;
        x_lo_d      = x_lo_q;
        x_hi_d      = x_hi_q;
        y_hi_d      = y_hi_q;
        wraddress_d = wraddress_q;
        data_d      = data_q;
        wren_d      = wren_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                wren_d = 1'b0;
                busy_d = 1'b0;
                // start wins over abort here; abort has no meaning while idle
                if (start) begin
                    mode_d = mode_in;
                    fill_d = fill_value;
                    if ((mode_in == ModeRect) && rect_bad) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        // Present the first pixel on this edge itself
                        x_lo_d      = start_x_lo;
                        x_hi_d      = start_x_hi;
                        y_hi_d      = start_y_hi;
                        x_d         = start_x_lo;
                        y_d         = start_y_lo;
                        wraddress_d = pixel_addr(start_x_lo, start_y_lo);
                        data_d      = pixel_data(mode_in, fill_value, start_x_lo, start_y_lo);
                        wren_d      = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = StWrite;
                    end
                end
            end

            StWrite: begin
                if (abort) begin
                    // The pixel presented this cycle is still written
                    wren_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (last_pixel) begin
                    wren_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    x_d         = x_step;
                    y_d         = y_step;
                    wraddress_d = pixel_addr(x_step, y_step);
                    data_d      = pixel_data(mode_q, fill_q, x_step, y_step);
                    wren_d      = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            StDone: begin
                wren_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                wren_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State, latched operands and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mode_q      <= ModeSolid;
            fill_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            x_lo_q      <= '0;
            x_hi_q      <= '0;
            y_hi_q      <= '0;
            wraddress_q <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_lo_q      <= x_lo_d;
            x_hi_q      <= x_hi_d;
            y_hi_q      <= y_hi_d;
            wraddress_q <= wraddress_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign wraddress = wraddress_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
